// File: rtl/hex_display_scanner_if.sv
// Bus between the CPU datapath and the seven-segment scan controller:
// the value/load strobe in, and the per-digit scan outputs back out.
interface hex_display_scanner_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic                pending;
    logic [3:0]          digit_nibble;
    logic [DIGITS-1:0]   digit_sel;
    logic                digit_blank;
    logic                frame_tick;

    modport master (
        output value, load,
        input  pending, digit_nibble, digit_sel, digit_blank, frame_tick
    );

    modport slave (
        input  value, load,
        output pending, digit_nibble, digit_sel, digit_blank, frame_tick
    );
endinterface

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex scanner for common-anode digits with a double-buffered value.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module hex_display_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    hex_display_scanner_if.slave bus
);
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int VAL_W = 4 * DIGITS;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VAL_W-1:0] shadow_q, shadow_d;
    logic [VAL_W-1:0] disp_q, disp_d;
    logic             pending_q, pending_d;
    logic             frame_tick_q, frame_tick_d;
    logic             adv, wrap;

    always_comb begin
        adv      = (pre_q == PRE_LAST);
        wrap     = adv && (idx_q == IDX_LAST);
        pre_d    = adv ? '0 : pre_q + 1'b1;
        idx_d    = idx_q;
        if (wrap) begin
            idx_d = '0;
        end else if (adv) begin
            idx_d = idx_q + 1'b1;
        end
        // A swap at the wrap always uses the old shadow, so a coincident load waits a frame.
        shadow_d  = bus.load ? bus.value : shadow_q;
        disp_d    = (wrap && pending_q) ? shadow_q : disp_q;
        pending_d = pending_q;
        if (bus.load) begin
            pending_d = 1'b1;
        end else if (wrap) begin
            pending_d = 1'b0;
        end
        frame_tick_d = wrap;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            disp_q       <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            disp_q       <= disp_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    logic [3:0]        nibble;
    logic [DIGITS-1:0] sel;
    logic              blank;

    always_comb begin
        nibble = 4'h0;
        sel    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nibble = disp_q[4*i +: 4];
                sel[i] = 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] top_idx;

    // Digit 0 is the floor of the search, so an all-zero value still shows one "0".
    always_comb begin
        top_idx = '0;
        for (int i = 1; i < DIGITS; i++) begin
            if (disp_q[4*i +: 4] != 4'h0) begin
                top_idx = IDX_W'(i);
            end
        end
        blank = (idx_q > top_idx);
    end
`else
    assign blank = 1'b0;
`endif

    assign bus.pending      = pending_q;
    assign bus.digit_nibble = nibble;
    assign bus.digit_sel    = sel;
    assign bus.digit_blank  = blank;
    assign bus.frame_tick   = frame_tick_q;
endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: vector table, multi-cycle corner sequences,
// and random traffic against a cycle-count based reference model.
module tb_hex_display_scanner;
    localparam int D = 4;
    localparam int R = 4;
    localparam int F = D * R;

    logic clk = 1'b0;
    logic rst = 1'b0;

    hex_display_scanner_if #(.DIGITS(D)) bus ();

    hex_display_scanner #(.DIGITS(D), .REFRESH_DIV(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: n counts clock edges since reset; everything else follows from it.
    int          m_n = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_disp = '0;
    logic        m_pend = 1'b0;
    logic        m_tick = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_idx();
        return (m_n / R) % D;
    endfunction

    function automatic logic exp_blank();
`ifdef LEADING_ZERO_BLANK_EN
        int hi = 0;
        for (int i = 0; i < D; i++) begin
            if (m_disp[4*i +: 4] != 4'h0) hi = i;
        end
        return exp_idx() > hi;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_model();
        int k = exp_idx();
        logic [3:0] es = 4'b1111;
        es[k] = 1'b0;
        check("model_sel", bus.digit_sel, es);
        check("model_nibble", bus.digit_nibble, m_disp[4*k +: 4]);
        check("model_pending", bus.pending, m_pend);
        check("model_frame_tick", bus.frame_tick, m_tick);
        check("model_blank", bus.digit_blank, exp_blank());
    endtask

    task automatic tick(input logic r, input logic ld, input logic [15:0] v);
        rst = r;
        bus.load = ld;
        bus.value = v;
        @(posedge clk);
        if (r) begin
            m_n = 0; m_shadow = '0; m_disp = '0; m_pend = 1'b0; m_tick = 1'b0;
        end else begin
            m_n++;
            m_tick = (m_n % F == 0);
            if (m_tick && m_pend) begin
                m_disp = m_shadow;
                m_pend = 1'b0;
            end
            if (ld) begin
                m_shadow = v;
                m_pend = 1'b1;
            end
        end
        #1;
        rst = 1'b0;
        bus.load = 1'b0;
        check_model();
    endtask

    task automatic wait_frame_start(input string name);
        int k = 0;
        tick(1'b0, 1'b0, 16'h0);
        while (bus.frame_tick !== 1'b1 && k < F + 1) begin
            tick(1'b0, 1'b0, 16'h0);
            k++;
        end
        check(name, bus.frame_tick, 1'b1);
    endtask

    // Called in the first cycle of a frame; samples each digit once.
    task automatic capture_frame(output logic [15:0] nib, output logic [3:0] blk);
        for (int d = 0; d < D; d++) begin
            if (d > 0) repeat (R) tick(1'b0, 1'b0, 16'h0);
            nib[4*d +: 4] = bus.digit_nibble;
            blk[d] = bus.digit_blank;
        end
    endtask

    typedef struct {
        int          cycles;
        logic        r;
        logic        ld;
        logic [15:0] v;
        logic [3:0]  sel;
        logic [3:0]  nib;
        logic        pend;
        logic        ftick;
    } vec_t;

    vec_t tbl[16];

    initial begin
        logic [15:0] nib;
        logic [3:0]  blk;
        logic [15:0] v;
        int          guard;

        tbl[0]  = '{1,  1'b1, 1'b0, 16'h0000, 4'b1110, 4'h0, 1'b0, 1'b0};
        tbl[1]  = '{3,  1'b0, 1'b0, 16'h0000, 4'b1110, 4'h0, 1'b0, 1'b0};
        tbl[2]  = '{1,  1'b0, 1'b0, 16'h0000, 4'b1101, 4'h0, 1'b0, 1'b0};
        tbl[3]  = '{3,  1'b0, 1'b0, 16'h0000, 4'b1101, 4'h0, 1'b0, 1'b0};
        tbl[4]  = '{1,  1'b0, 1'b0, 16'h0000, 4'b1011, 4'h0, 1'b0, 1'b0};
        tbl[5]  = '{4,  1'b0, 1'b0, 16'h0000, 4'b0111, 4'h0, 1'b0, 1'b0};
        tbl[6]  = '{3,  1'b0, 1'b0, 16'h0000, 4'b0111, 4'h0, 1'b0, 1'b0};
        tbl[7]  = '{1,  1'b0, 1'b0, 16'h0000, 4'b1110, 4'h0, 1'b0, 1'b1};
        tbl[8]  = '{1,  1'b0, 1'b0, 16'h0000, 4'b1110, 4'h0, 1'b0, 1'b0};
        tbl[9]  = '{1,  1'b0, 1'b1, 16'hBEEF, 4'b1110, 4'h0, 1'b1, 1'b0};
        tbl[10] = '{13, 1'b0, 1'b0, 16'h0000, 4'b0111, 4'h0, 1'b1, 1'b0};
        tbl[11] = '{1,  1'b0, 1'b0, 16'h0000, 4'b1110, 4'hF, 1'b0, 1'b1};
        tbl[12] = '{4,  1'b0, 1'b0, 16'h0000, 4'b1101, 4'hE, 1'b0, 1'b0};
        tbl[13] = '{4,  1'b0, 1'b0, 16'h0000, 4'b1011, 4'hE, 1'b0, 1'b0};
        tbl[14] = '{4,  1'b0, 1'b0, 16'h0000, 4'b0111, 4'hB, 1'b0, 1'b0};
        tbl[15] = '{4,  1'b0, 1'b0, 16'h0000, 4'b1110, 4'hF, 1'b0, 1'b1};

        bus.load = 1'b0;
        bus.value = '0;
        @(negedge clk);

        for (int e = 0; e < 16; e++) begin
            for (int c = 0; c < tbl[e].cycles; c++) begin
                tick((c == 0) ? tbl[e].r : 1'b0, (c == 0) ? tbl[e].ld : 1'b0, tbl[e].v);
            end
            check($sformatf("vec%0d_sel", e), bus.digit_sel, tbl[e].sel);
            check($sformatf("vec%0d_nibble", e), bus.digit_nibble, tbl[e].nib);
            check($sformatf("vec%0d_pending", e), bus.pending, tbl[e].pend);
            check($sformatf("vec%0d_frame_tick", e), bus.frame_tick, tbl[e].ftick);
        end

        // Two loads in one frame: only the last survives.
        repeat (3) tick(1'b0, 1'b0, 16'h0);
        tick(1'b0, 1'b1, 16'h1234);
        repeat (2) tick(1'b0, 1'b0, 16'h0);
        tick(1'b0, 1'b1, 16'hA5A5);
        wait_frame_start("two_loads_wrap");
        check("two_loads_pending_clear", bus.pending, 1'b0);
        capture_frame(nib, blk);
        check("two_loads_frame", nib, 16'hA5A5);

        // Load coincident with a swapping wrap.
        tick(1'b0, 1'b1, 16'h1111);
        guard = 0;
        while ((m_n % F) != F - 1 && guard < F) begin
            tick(1'b0, 1'b0, 16'h0);
            guard++;
        end
        check("coincident_align", m_n % F, F - 1);
        tick(1'b0, 1'b1, 16'h5678);
        check("coincident_frame_tick", bus.frame_tick, 1'b1);
        check("coincident_pending_kept", bus.pending, 1'b1);
        capture_frame(nib, blk);
        check("coincident_first_frame", nib, 16'h1111);
        wait_frame_start("coincident_second_wrap");
        check("coincident_pending_clear", bus.pending, 1'b0);
        capture_frame(nib, blk);
        check("coincident_second_frame", nib, 16'h5678);

        // Reset at digit 2 while a value is pending.
        guard = 0;
        while (exp_idx() != 2 && guard < F) begin
            tick(1'b0, 1'b0, 16'h0);
            guard++;
        end
        tick(1'b0, 1'b1, 16'h9999);
        check("rst_pre_pending", bus.pending, 1'b1);
        check("rst_pre_sel", bus.digit_sel, 4'b1011);
        tick(1'b1, 1'b0, 16'h0);
        check("rst_sel", bus.digit_sel, 4'b1110);
        check("rst_pending", bus.pending, 1'b0);
        check("rst_nibble", bus.digit_nibble, 4'h0);
        repeat (3) begin
            tick(1'b0, 1'b0, 16'h0);
            check("rst_dwell_sel", bus.digit_sel, 4'b1110);
        end
        tick(1'b0, 1'b0, 16'h0);
        check("rst_first_adv_sel", bus.digit_sel, 4'b1101);
        wait_frame_start("rst_wrap");
        capture_frame(nib, blk);
        check("rst_disp_cleared", nib, 16'h0000);

        // Leading-zero blanking.
        tick(1'b0, 1'b1, 16'h00A0);
        wait_frame_start("blank_wrap_a0");
        capture_frame(nib, blk);
        check("blank_a0_nibbles", nib, 16'h00A0);
`ifdef LEADING_ZERO_BLANK_EN
        check("blank_a0_mask", blk, 4'b1100);
`else
        check("blank_a0_mask", blk, 4'b0000);
`endif
        tick(1'b0, 1'b1, 16'h0000);
        wait_frame_start("blank_wrap_zero");
        capture_frame(nib, blk);
        check("blank_zero_nibbles", nib, 16'h0000);
`ifdef LEADING_ZERO_BLANK_EN
        check("blank_zero_mask", blk, 4'b1110);
`else
        check("blank_zero_mask", blk, 4'b0000);
`endif

        // Random loads, values with random zero nibbles, and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            v = 16'($urandom);
            for (int d = 0; d < D; d++) begin
                if ($urandom_range(0, 1) == 0) v[4*d +: 4] = 4'h0;
            end
            tick($urandom_range(0, 299) == 0, $urandom_range(0, 5) == 0, v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
